// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  localparam int unsigned DEF_WORD_W = 10;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// Shifts a loaded byte out MSB first over DATA_W cycles; output is 0 when idle.
module spi_tx_serializer
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              miso_o
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Next-state: clear beats load, load beats shifting.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      shreg_d = data_i;
      cnt_d   = CntW'(DATA_W);
    end else if (cnt_q != '0) begin
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - CntW'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign miso_o = (cnt_q != '0) & shreg_q[DATA_W-1];

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises command frames for the RAM and returns read bytes on MISO.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned     CntW    = $clog2(WORD_W + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WORD_W - 1);
  // Count parked here once a frame completes, so a held-low ss_n cannot start another.
  localparam logic [CntW-1:0] Done    = CntW'(WORD_W);

  state_e              state_q, state_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_addr_seen_q, rd_addr_seen_d;
  logic                rd_wait_q, rd_wait_d;
  logic                tx_load;

  // Next-state and control: frame capture, read-address tracking, tx wait window.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    rd_wait_d      = rd_wait_q;
    tx_load        = 1'b0;

    if (rx_valid_q) begin
      unique case (rx_data_q[WORD_W-1 -: 2])
        CMD_RD_ADDR:              rd_addr_seen_d = 1'b1;
        CMD_RD_DATA:              rd_addr_seen_d = 1'b0;
        CMD_WR_ADDR, CMD_WR_DATA: rd_addr_seen_d = rd_addr_seen_q;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (!ss_n) state_d = StChkCmd;
      end
      StChkCmd: begin
        if (ss_n) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
        end else begin
          shift_d   = {shift_q[WORD_W-3:0], mosi};
          bit_cnt_d = CntW'(1);
          state_d   = mosi ? (rd_addr_seen_q ? StReadData : StReadAdd) : StWrite;
        end
      end
      default: begin
        // Last bit is taken even if ss_n rises on the same cycle.
        if (bit_cnt_q == LastBit) begin
          rx_data_d  = {shift_q, mosi};
          rx_valid_d = 1'b1;
          bit_cnt_d  = Done;
          rd_wait_d  = (state_q == StReadData) && !ss_n;
        end else if (bit_cnt_q != Done && !ss_n) begin
          shift_d   = {shift_q[WORD_W-3:0], mosi};
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
        if (rd_wait_q && tx_valid && !ss_n) begin
          tx_load   = 1'b1;
          rd_wait_d = 1'b0;
        end
        if (ss_n) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          rd_wait_d = 1'b0;
        end
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      rd_wait_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      rd_wait_q      <= rd_wait_d;
    end
  end

  spi_tx_serializer #(
    .DATA_W(DATA_W)
  ) u_tx (
    .clk_i  (clk),
    .rst_i  (rst),
    .clear_i(ss_n),
    .load_i (tx_load),
    .data_i (tx_data),
    .miso_o (miso)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
